apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
APB requester, the initiating end of the peripheral bus our register-block completers sit on. Converts a simple valid/ready command port into compliant APB SETUP/ACCESS transfers. Returns one response per command carrying read data, pslverr status and a wait-state timeout flag. One outstanding transfer at a time; sits between a local controller/CPU shim and the APB completers.

Parameters:
ADDR_W, 8, paddr/cmd_addr width
DATA_W, 8, pwdata/prdata/cmd_wdata/rsp_rdata width
TIMEOUT, 16, max ACCESS cycles waiting for pready before abort; 0 disables timeout

Ports:
pclk  in  1  bus clock, all logic rising-edge
preset_n  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  target address
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  DATA_W  read data (0 for writes/timeouts)
rsp_err  out  1  pslverr captured, or timeout
rsp_timeout  out  1  transfer aborted by timeout
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDR_W  APB address
pwdata  out  DATA_W  APB write data
prdata  in  DATA_W  APB read data
pready  in  1  completer ready
pslverr  in  1  completer error

Behaviour:
- Reset (async assert, sync release): state IDLE; psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, rsp_timeout all 0; wait counter 0. cmd_ready is state-decoded: 1 in IDLE, including during reset.
- Reset mid-transfer: bus outputs drop to 0 immediately; no response is produced.
- States: IDLE, SETUP, ACCESS.
- IDLE: cmd_ready=1. If cmd_valid: latch write/addr/wdata into paddr/pwdata/pwrite; psel<=1; go SETUP. Otherwise bus outputs hold 0.
- SETUP: psel=1, penable=0, cmd_ready=0. Always moves to ACCESS next cycle (penable<=1). pready is ignored in SETUP.
- ACCESS: psel=1, penable=1; paddr/pwrite/pwdata stay stable until completion.
  - If pready=1: sample pslverr into rsp_err; rsp_rdata<=prdata for reads, 0 for writes; rsp_timeout<=0; rsp_valid<=1; psel/penable<=0; go IDLE.
  - If pready=0: wait counter increments. If TIMEOUT!=0 and counter reaches TIMEOUT-1 in that cycle, abort: psel/penable<=0; rsp_valid<=1, rsp_err<=1, rsp_timeout<=1, rsp_rdata<=0; go IDLE.
  - Wait counter clears on entry to SETUP. Its width is clog2(TIMEOUT+1), minimum 1.
- Latency: command accepted at edge N gives SETUP at N+1 and ACCESS at N+2. With zero wait states, rsp_valid is high and cmd_ready is 1 in cycle N+3. Back-to-back throughput is one transfer per 3 cycles.
- Timeout cycle count: the abort takes effect on the TIMEOUT-th consecutive ACCESS cycle with pready=0.
- Response outputs:
  - rsp_valid is high for exactly one cycle, coincident with the first IDLE cycle.
  - rsp_rdata/rsp_err/rsp_timeout hold their values until the next response.
  - A new command may be accepted in the same cycle rsp_valid is high.
- pready and pslverr arriving when not in ACCESS are ignored.
- pwdata holds the latched value for reads too. Completers must ignore it.

Decomposition:
- Package apb_pkg: state enum (IDLE/SETUP/ACCESS), default ADDR_W/DATA_W constants, and a clog2 helper for the counter width.
- One sub-module: apb_wait_timer, holding the wait counter with clear, enable and expired output, parameterised by TIMEOUT.

Test Plan:
- Write 0xA5 to addr 0x03; completer pready=1 in first ACCESS -> psel high at N+1..N+2, penable high at N+2 only; rsp_valid at N+3 with rsp_err=0, rsp_rdata=0x00.
- Read addr 0x05; completer inserts 3 wait states then pready=1 with prdata=0x3C -> paddr stable through all ACCESS cycles; rsp_rdata=0x3C, rsp_err=0.
- Write to addr 0x20; completer replies pready=1, pslverr=1 -> rsp_valid with rsp_err=1, rsp_timeout=0.
- TIMEOUT=4, pready held 0 -> psel drops after the 4th ACCESS cycle; rsp_valid with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- cmd_valid held high for 3 commands, zero wait states -> transfers start every 3 cycles, and each new command is accepted in its rsp_valid cycle.
- preset_n pulled low during ACCESS of a read -> psel/penable go 0 asynchronously, no rsp_valid, cmd_ready=1; after release the next command completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared definitions for the APB requester: FSM states, default bus widths
// and the wait-counter width helper.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   localparam int unsigned DEF_ADDR_W = 8;
   localparam int unsigned DEF_DATA_W = 8;

   // Bits needed to count 0..t, never less than one bit.
   function automatic int unsigned cnt_width(input int unsigned t);
      return (t < 2) ? 1 : $clog2(t + 1);
   endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Wait-state counter for the ACCESS phase. Flags expiry when the current
// stalled cycle is the TIMEOUT-th consecutive one; TIMEOUT=0 never expires.
module apb_wait_timer
   import apb_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned W = cnt_width(TIMEOUT);
   localparam logic [W-1:0] LAST = W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   logic [W-1:0] count;

   // Count stalled ACCESS cycles; restart at the beginning of each transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      count <= '0;
      else if (clear)  count <= '0;
      else if (enable) count <= count + W'(1);
   end

   // Expiry is judged on the count before this cycle's increment.
   always_comb begin
      expired = 1'b0;
      if (TIMEOUT != 0) expired = (count == LAST);
   end

endmodule

// File: rtl/apb_master_bridge.sv
// APB requester: turns a valid/ready command into one SETUP/ACCESS transfer
// and returns a single-cycle response with read data, error and timeout.
module apb_master_bridge
   import apb_pkg::*;
#(
   parameter int unsigned ADDR_W  = DEF_ADDR_W,
   parameter int unsigned DATA_W  = DEF_DATA_W,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic              pclk,
   input  logic              preset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_timeout,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready,
   input  logic              pslverr
);

   state_t state, state_next;
   logic   accept, complete, abort, wait_en, expired;

   apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (pclk),
      .rst_n   (preset_n),
      .clear   (accept),
      .enable  (wait_en),
      .expired (expired)
   );

   // State register; reset forces IDLE so psel/penable drop at once.
   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) state <= IDLE;
      else           state <= state_next;
   end

   // Next-state logic and state-decoded handshake/bus controls.
   always_comb begin
      state_next = state;
      cmd_ready  = 1'b0;
      psel       = 1'b0;
      penable    = 1'b0;
      accept     = 1'b0;
      complete   = 1'b0;
      abort      = 1'b0;
      wait_en    = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               accept     = 1'b1;
               state_next = SETUP;
            end
         end
         SETUP: begin
            psel       = 1'b1;
            state_next = ACCESS;
         end
         ACCESS: begin
            psel    = 1'b1;
            penable = 1'b1;
            if (pready) begin
               complete   = 1'b1;
               state_next = IDLE;
            end else begin
               wait_en = 1'b1;
               if (expired) begin
                  abort      = 1'b1;
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Transfer attributes latched on accept, cleared when the transfer ends;
   // response fields captured at completion or abort and held until the next.
   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         pwrite      <= 1'b0;
         paddr       <= '0;
         pwdata      <= '0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         rsp_valid <= complete | abort;
         if (accept) begin
            pwrite <= cmd_write;
            paddr  <= cmd_addr;
            pwdata <= cmd_wdata;
         end else if (complete || abort) begin
            pwrite <= 1'b0;
            paddr  <= '0;
            pwdata <= '0;
         end
         if (complete) begin
            rsp_err     <= pslverr;
            rsp_rdata   <= pwrite ? '0 : prdata;
            rsp_timeout <= 1'b0;
         end else if (abort) begin
            rsp_err     <= 1'b1;
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge with TIMEOUT=4.
module tb_apb_master_bridge;

   logic       pclk = 1'b0;
   logic       preset_n;
   logic       cmd_valid, cmd_ready, cmd_write;
   logic [7:0] cmd_addr, cmd_wdata;
   logic       rsp_valid, rsp_err, rsp_timeout;
   logic [7:0] rsp_rdata;
   logic       psel, penable, pwrite;
   logic [7:0] paddr, pwdata, prdata;
   logic       pready, pslverr;

   int n_tests = 0;
   int n_fail  = 0;

   apb_master_bridge #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(4)) dut (
      .pclk        (pclk),
      .preset_n    (preset_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_write   (cmd_write),
      .cmd_addr    (cmd_addr),
      .cmd_wdata   (cmd_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .rsp_timeout (rsp_timeout),
      .psel        (psel),
      .penable     (penable),
      .pwrite      (pwrite),
      .paddr       (paddr),
      .pwdata      (pwdata),
      .prdata      (prdata),
      .pready      (pready),
      .pslverr     (pslverr)
   );

   always #5 pclk = ~pclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; checks and drives happen 1 time unit after it.
   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic set_cmd(input logic v, input logic w, input logic [7:0] a, input logic [7:0] d);
      cmd_valid = v;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
   endtask

   initial begin
      preset_n = 1'b0;
      set_cmd(1'b0, 1'b0, 8'h00, 8'h00);
      prdata  = 8'h00;
      pready  = 1'b0;
      pslverr = 1'b0;
      #12;
      // reset state, including cmd_ready while reset is asserted
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_psel",      32'(psel),      32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      preset_n = 1'b1;
      tick();
      chk("rst_paddr", 32'(paddr), 32'd0);

      // write 0xA5 to 0x03, zero wait states; pready already high in SETUP is ignored
      set_cmd(1'b1, 1'b1, 8'h03, 8'hA5);
      pready = 1'b1;
      tick();                               // N+1: SETUP
      set_cmd(1'b0, 1'b0, 8'h00, 8'h00);
      chk("wr_setup_psel",    32'(psel),      32'd1);
      chk("wr_setup_penable", 32'(penable),   32'd0);
      chk("wr_setup_ready",   32'(cmd_ready), 32'd0);
      tick();                               // N+2: ACCESS
      chk("wr_acc_penable", 32'(penable), 32'd1);
      chk("wr_acc_paddr",   32'(paddr),   32'h03);
      chk("wr_acc_pwdata",  32'(pwdata),  32'hA5);
      chk("wr_acc_pwrite",  32'(pwrite),  32'd1);
      tick();                               // N+3: response
      chk("wr_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("wr_rsp_err",   32'(rsp_err),   32'd0);
      chk("wr_rsp_rdata", 32'(rsp_rdata), 32'h00);
      chk("wr_rsp_psel",  32'(psel),      32'd0);
      chk("wr_rsp_ready", 32'(cmd_ready), 32'd1);
      tick();
      chk("wr_rsp_pulse", 32'(rsp_valid), 32'd0);

      // read 0x05 with 3 wait states; completion lands on the 4th ACCESS cycle (= TIMEOUT)
      pready = 1'b0;
      prdata = 8'hEE;
      set_cmd(1'b1, 1'b0, 8'h05, 8'h11);
      tick();                               // SETUP
      set_cmd(1'b0, 1'b0, 8'h00, 8'h00);
      tick();                               // ACCESS 1
      chk("rd_w1_paddr", 32'(paddr), 32'h05);
      tick();                               // ACCESS 2
      chk("rd_w2_paddr",   32'(paddr),   32'h05);
      chk("rd_w2_penable", 32'(penable), 32'd1);
      tick();                               // ACCESS 3
      chk("rd_w3_paddr", 32'(paddr), 32'h05);
      tick();                               // ACCESS 4
      chk("rd_w4_paddr",  32'(paddr),  32'h05);
      chk("rd_w4_pwrite", 32'(pwrite), 32'd0);
      chk("rd_w4_pwdata", 32'(pwdata), 32'h11);
      pready = 1'b1;
      prdata = 8'h3C;
      tick();
      chk("rd_rsp_valid",   32'(rsp_valid),   32'd1);
      chk("rd_rsp_rdata",   32'(rsp_rdata),   32'h3C);
      chk("rd_rsp_err",     32'(rsp_err),     32'd0);
      chk("rd_rsp_timeout", 32'(rsp_timeout), 32'd0);
      tick();
      chk("rd_rdata_hold", 32'(rsp_rdata), 32'h3C);

      // write 0x20 answered with pslverr
      pslverr = 1'b1;
      set_cmd(1'b1, 1'b1, 8'h20, 8'h5E);
      tick();
      set_cmd(1'b0, 1'b0, 8'h00, 8'h00);
      tick();
      tick();
      chk("err_rsp_valid",   32'(rsp_valid),   32'd1);
      chk("err_rsp_err",     32'(rsp_err),     32'd1);
      chk("err_rsp_timeout", 32'(rsp_timeout), 32'd0);
      chk("err_rsp_rdata",   32'(rsp_rdata),   32'h00);
      pslverr = 1'b0;
      tick();
      chk("err_hold", 32'(rsp_err), 32'd1);

      // timeout: pready held low, abort after the 4th ACCESS cycle
      pready = 1'b0;
      prdata = 8'h77;
      set_cmd(1'b1, 1'b0, 8'h11, 8'h00);
      tick();                               // SETUP
      set_cmd(1'b0, 1'b0, 8'h00, 8'h00);
      tick(); tick(); tick(); tick();       // ACCESS 1..4
      chk("to_acc4_psel",    32'(psel),      32'd1);
      chk("to_acc4_rsp",     32'(rsp_valid), 32'd0);
      tick();
      chk("to_psel",        32'(psel),        32'd0);
      chk("to_rsp_valid",   32'(rsp_valid),   32'd1);
      chk("to_rsp_err",     32'(rsp_err),     32'd1);
      chk("to_rsp_timeout", 32'(rsp_timeout), 32'd1);
      chk("to_rsp_rdata",   32'(rsp_rdata),   32'h00);
      tick();
      chk("to_timeout_hold", 32'(rsp_timeout), 32'd1);

      // back-to-back: cmd_valid held for three commands, zero wait states
      pready = 1'b1;
      set_cmd(1'b1, 1'b1, 8'h40, 8'hC0);
      tick();                               // A SETUP
      chk("b2b_a_paddr", 32'(paddr),     32'h40);
      chk("b2b_a_ready", 32'(cmd_ready), 32'd0);
      set_cmd(1'b1, 1'b1, 8'h41, 8'hC1);
      tick();                               // A ACCESS
      tick();                               // A response, B accepted here
      chk("b2b_a_rsp",   32'(rsp_valid), 32'd1);
      chk("b2b_a_rdy",   32'(cmd_ready), 32'd1);
      tick();                               // B SETUP
      chk("b2b_b_paddr", 32'(paddr), 32'h41);
      chk("b2b_b_psel",  32'(psel),  32'd1);
      set_cmd(1'b1, 1'b1, 8'h42, 8'hC2);
      tick();                               // B ACCESS
      tick();                               // B response, C accepted here
      chk("b2b_b_rsp",   32'(rsp_valid), 32'd1);
      tick();                               // C SETUP
      chk("b2b_c_paddr",  32'(paddr),  32'h42);
      chk("b2b_c_pwdata", 32'(pwdata), 32'hC2);
      set_cmd(1'b0, 1'b0, 8'h00, 8'h00);
      tick();                               // C ACCESS
      tick();                               // C response
      chk("b2b_c_rsp", 32'(rsp_valid), 32'd1);
      tick();
      chk("b2b_idle_psel", 32'(psel),      32'd0);
      chk("b2b_idle_rsp",  32'(rsp_valid), 32'd0);

      // reset asserted during ACCESS of a read
      pready = 1'b0;
      set_cmd(1'b1, 1'b0, 8'h09, 8'h00);
      tick();                               // SETUP
      set_cmd(1'b0, 1'b0, 8'h00, 8'h00);
      tick();                               // ACCESS
      chk("mid_pre_penable", 32'(penable), 32'd1);
      #1 preset_n = 1'b0;
      #1;
      chk("mid_psel",      32'(psel),      32'd0);
      chk("mid_penable",   32'(penable),   32'd0);
      chk("mid_ready",     32'(cmd_ready), 32'd1);
      chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("mid_paddr",     32'(paddr),     32'h00);
      #2 preset_n = 1'b1;
      pready = 1'b1;
      tick();
      chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
      prdata = 8'h5A;
      set_cmd(1'b1, 1'b0, 8'h0A, 8'h00);
      tick();
      set_cmd(1'b0, 1'b0, 8'h00, 8'h00);
      tick();
      chk("post_rst_paddr", 32'(paddr), 32'h0A);
      tick();
      chk("post_rst_rsp",   32'(rsp_valid), 32'd1);
      chk("post_rst_rdata", 32'(rsp_rdata), 32'h5A);
      chk("post_rst_err",   32'(rsp_err),   32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Absolute bound so the run always ends.
   initial begin
      #20000;
      $display("FAIL watchdog: observed no completion expected finish before 20000");
      $fatal(1);
   end

endmodule
